// File: rtl/imem_dump_pkg.sv
// Shared definitions for the instruction-memory dump path: FSM encoding,
// byte-interface widths and address helper.
package imem_dump_pkg;

    localparam int WORD_BYTES  = 4;
    localparam int TX_W        = 8;
    localparam int WORD_W      = WORD_BYTES * TX_W;
    localparam int BYTE_IDX_W  = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Byte address of word idx; wraps mod 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imem_dump_serializer.sv
// Holds one 32-bit word and presents its bytes LSB-first over valid/ready.
// The owner drives en (= tx_valid); fire is the handshake for this byte.
module word_byte_serializer
    import imem_dump_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] word_in,
    input  logic              en,
    input  logic              ready,
    output logic [TX_W-1:0]   data,
    output logic              last,
    output logic              fire
);

    logic [WORD_W-1:0]     word;
    logic [BYTE_IDX_W-1:0] k;

    assign fire = en & ready;
    assign last = (k == BYTE_IDX_W'(WORD_BYTES - 1));
    assign data = word[int'(k) * TX_W +: TX_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            k    <= '0;
        end else if (load) begin
            word <= word_in;
            k    <= '0;
        end else if (fire) begin
            k <= k + 1'b1;
        end
    end

endmodule

// File: rtl/imem_dump.sv
// Reads NWORDS words from instruction memory starting at BASE_ADDR and streams
// them little-endian over a byte valid/ready port, with a running checksum.
module imem_dump
    import imem_dump_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          NWORDS    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [31:0]       mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [TX_W-1:0]   tx_data,
    output logic [31:0]       checksum
);

    localparam int IDX_W = $clog2(NWORDS + 1);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       sum;
    logic              idx_last;
    logic              byte_fire;
    logic              byte_last;
    logic              word_done;

    assign idx_last  = (idx == IDX_W'(NWORDS - 1));
    assign word_done = byte_fire & byte_last;

    word_byte_serializer u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (state == S_WAIT),
        .word_in (mem_rdata),
        .en      (tx_valid),
        .ready   (tx_ready),
        .data    (tx_data),
        .last    (byte_last),
        .fire    (byte_fire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            sum   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx <= '0;
                        sum <= '0;
                    end
                end
                S_WAIT: sum <= sum + mem_rdata;
                S_SEND: if (word_done && !idx_last) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_READ;
            S_READ:  state_nx = S_WAIT;
            S_WAIT:  state_nx = S_SEND;
            S_SEND:  if (word_done) state_nx = idx_last ? S_DONE : S_READ;
            S_DONE:  state_nx = start ? S_READ : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // All outputs decode registered state; tx_ready only steers next state.
    assign busy     = (state == S_READ) || (state == S_WAIT) || (state == S_SEND);
    assign done     = (state == S_DONE);
    assign mem_re   = (state == S_READ);
    assign tx_valid = (state == S_SEND);
    assign mem_addr = word_addr(BASE_ADDR, 32'(idx));
    assign checksum = sum;

endmodule

// File: tb/tb_imem_dump.sv
// Directed bench for imem_dump: two instances (two-word image at 0, one-word
// image at the top of the address space) with 1-cycle-latency memory models.
module tb_imem_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic        mem_re_a, mem_re_b;
    logic [31:0] mem_addr_a, mem_addr_b, rdata_a, rdata_b;
    logic        tx_valid_a, tx_valid_b, ready_a, ready_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic [31:0] checksum_a, checksum_b;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] SUM_A = 32'hC18001A6;

    logic [7:0] exp_bytes [8] = '{8'h93, 8'h00, 8'h80, 8'h3e, 8'h13, 8'h01, 8'h00, 8'h83};
    logic [7:0] exp_b     [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    always #5 clk = ~clk;

    imem_dump #(.BASE_ADDR(32'h0), .NWORDS(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_re(mem_re_a), .mem_addr(mem_addr_a), .mem_rdata(rdata_a),
        .tx_valid(tx_valid_a), .tx_ready(ready_a), .tx_data(tx_data_a),
        .checksum(checksum_a)
    );

    imem_dump #(.BASE_ADDR(32'hFFFF_FFFC), .NWORDS(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_re(mem_re_b), .mem_addr(mem_addr_b), .mem_rdata(rdata_b),
        .tx_valid(tx_valid_b), .tx_ready(ready_b), .tx_data(tx_data_b),
        .checksum(checksum_b)
    );

    // Poison data outside the read slot so a mistimed latch shows up.
    always @(posedge clk) begin
        if (mem_re_a)
            rdata_a <= (mem_addr_a == 32'h0) ? 32'h3e800093 :
                       (mem_addr_a == 32'h4) ? 32'h83000113 : 32'h0;
        else
            rdata_a <= 32'hBAD0BAD0;
        if (mem_re_b)
            rdata_b <= (mem_addr_b == 32'hFFFF_FFFC) ? 32'hDEADBEEF : 32'h0;
        else
            rdata_b <= 32'hBAD0BAD0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One dump on instance A. c counts cycles after the start-sampling edge.
    task automatic run(input bit skip_start, input int pulse_at, input int stall_lo,
                       input int stall_hi, input int exp_done_c, input logic [31:0] exp_sum);
        int nb, re_cnt, first_valid;
        nb = 0; re_cnt = 0; first_valid = 0;
        if (!skip_start) begin
            start_a = 1'b1;
            tick();
        end
        for (int c = 1; c <= exp_done_c; c++) begin
            start_a = (c == pulse_at);
            ready_a = !(c >= stall_lo && c <= stall_hi);
            check("busy", 32'(busy_a), 32'(c < exp_done_c));
            check("done", 32'(done_a), 32'(c == exp_done_c));
            if (c >= stall_lo && c <= stall_hi)
                check("stall_valid", 32'(tx_valid_a), 32'd1);
            if (mem_re_a) begin
                check("mem_addr", mem_addr_a, 32'(4 * re_cnt));
                check("re_after_word", 32'(nb), 32'(4 * re_cnt));
                re_cnt++;
            end
            if (tx_valid_a) begin
                if (first_valid == 0) first_valid = c;
                if (nb < 8) check("tx_data", 32'(tx_data_a), 32'(exp_bytes[nb]));
                else        check("extra_byte", 32'(nb), 32'd7);
                if (ready_a) nb++;
            end
            if (c == exp_done_c) check("checksum", checksum_a, exp_sum);
            tick();
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        check("bytes_sent", 32'(nb), 32'd8);
        check("mem_reads", 32'(re_cnt), 32'd2);
        check("first_valid", 32'(first_valid), 32'd3);
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        tick(); tick();
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_mem_re", 32'(mem_re_a), 32'd0);
        check("rst_addr_a", mem_addr_a, 32'h0);
        check("rst_valid", 32'(tx_valid_a), 32'd0);
        check("rst_data", 32'(tx_data_a), 32'd0);
        check("rst_sum", checksum_a, 32'd0);
        check("rst_addr_b", mem_addr_b, 32'hFFFF_FFFC);
        rst = 1'b0;

        // plain run, ready always high
        run(1'b0, 0, 99, 0, 13, SUM_A);
        check("idle_busy", 32'(busy_a), 32'd0);
        check("sum_hold", checksum_a, SUM_A);

        // 5 cycles of backpressure on byte 80
        run(1'b0, 0, 5, 9, 18, SUM_A);

        // start pulsed mid-run is ignored
        run(1'b0, 4, 99, 0, 13, SUM_A);
        check("no_restart", 32'(busy_a), 32'd0);

        // reset during the second word's WAIT cycle
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_mem_re", 32'(mem_re_a), 32'd0);
        check("abort_addr", mem_addr_a, 32'h0);
        check("abort_valid", 32'(tx_valid_a), 32'd0);
        check("abort_data", 32'(tx_data_a), 32'd0);
        check("abort_sum", checksum_a, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("abort_done", 32'(done_a), 32'd0);
            tick();
        end
        run(1'b0, 0, 99, 0, 13, SUM_A);

        // start held in DONE chains straight into READ with a cleared sum
        run(1'b0, 13, 99, 0, 13, SUM_A);
        check("chain_re", 32'(mem_re_a), 32'd1);
        check("chain_sum_clr", checksum_a, 32'd0);
        check("chain_done", 32'(done_a), 32'd0);
        run(1'b1, 0, 99, 0, 13, SUM_A);
        check("single_done", 32'(done_a), 32'd0);

        // one word at the top of the address space
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            check("b_mem_re", 32'(mem_re_b), 32'(c == 1));
            if (mem_re_b) check("b_addr", mem_addr_b, 32'hFFFF_FFFC);
            check("b_valid", 32'(tx_valid_b), 32'(c >= 3 && c <= 6));
            if (tx_valid_b && c >= 3 && c <= 6)
                check("b_data", 32'(tx_data_b), 32'(exp_b[c-3]));
            check("b_done", 32'(done_b), 32'(c == 7));
            if (c == 7) check("b_sum", checksum_b, 32'hDEADBEEF);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
